// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath types, sizes and window bit-offset helper
package cnn_pkg;
    localparam int WIDTH       = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int ACCM_WIDTH  = 2 * WIDTH + 4;
    localparam int WIN_ELEMS   = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic signed [WIDTH-1:0] pixel_t;

    // LSB of window element (r, c) in a flat window bus of w-bit elements
    function automatic int elem_lsb(input int r, input int c, input int w);
        return (r * KERNEL_SIZE + c) * w;
    endfunction
endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one-row line buffer, async read, clocked write, contents not reset
module line_buffer_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read is combinational, so a same-address write lands after the old value was used
    assign rd_data_o = mem_q[rd_addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 sliding-window generator feeding the convolution MAC
module conv_window_gen #(
    parameter int WIDTH       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [WIDTH-1:0]                        in_pixel,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*WIDTH-1:0] out_window,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last
);
    import cnn_pkg::*;

    localparam int NE = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [NE*WIDTH-1:0] win_q, win_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [WIDTH-1:0]    lb0_rd, lb1_rd;
    logic                accept, col_end, row_end, gen_win;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col_q == CW'(IMG_WIDTH - 1));
    assign row_end  = (row_q == RW'(IMG_HEIGHT - 1));
    // Left two columns of each row mix in data from the previous row, so they never emit
    assign gen_win  = (row_q >= RW'(2)) && (col_q >= CW'(2));

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(WIDTH)) u_lb0 (
        .clk       (clk),
        .rd_addr_i (col_q),
        .rd_data_o (lb0_rd),
        .wr_en_i   (accept),
        .wr_addr_i (col_q),
        .wr_data_i (in_pixel)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(WIDTH)) u_lb1 (
        .clk       (clk),
        .rd_addr_i (col_q),
        .rd_data_o (lb1_rd),
        .wr_en_i   (accept),
        .wr_addr_i (col_q),
        .wr_data_i (lb0_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                win_d[elem_lsb(r, 0, WIDTH) +: WIDTH] = win_q[elem_lsb(r, 1, WIDTH) +: WIDTH];
                win_d[elem_lsb(r, 1, WIDTH) +: WIDTH] = win_q[elem_lsb(r, 2, WIDTH) +: WIDTH];
            end
            win_d[elem_lsb(0, 2, WIDTH) +: WIDTH] = lb1_rd;
            win_d[elem_lsb(1, 2, WIDTH) +: WIDTH] = lb0_rd;
            win_d[elem_lsb(2, 2, WIDTH) +: WIDTH] = in_pixel;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept && gen_win) begin
            out_valid_d = 1'b1;
            out_last_d  = row_end && col_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_window = win_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized self-checking bench for conv_window_gen on a 5x5 image
module tb_conv_window_gen;
    localparam int W  = 8;
    localparam int IW = 5;
    localparam int IH = 5;

    typedef struct {
        logic [71:0] win;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] out_window;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          acc_cnt = 0;
    int          valid_after = -1;
    bit          seen_valid = 1'b0;
    int          mr = 0;
    int          mc = 0;
    logic [7:0]  img [IH][IW];
    exp_t        q[$];
    logic [71:0] ramp_first, ramp_last;

    always #5 clk = ~clk;

    conv_window_gen #(.WIDTH(W), .KERNEL_SIZE(3), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: keep the whole frame as an image and cut the 3x3 neighbourhood out of it
    task automatic model_accept(input logic [7:0] px);
        exp_t e;
        img[mr][mc] = px;
        acc_cnt++;
        if (mr >= 2 && mc >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[(r*3+c)*8 +: 8] = img[mr-2+r][mc-2+c];
            e.last = (mr == IH-1) && (mc == IW-1);
            q.push_back(e);
        end
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr = (mr + 1) % IH;
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] px, input bit rdy, output bit acc);
        in_valid  = v;
        in_pixel  = px;
        out_ready = rdy;
        #2;
        check("in_ready", {71'd0, in_ready}, {71'd0, (q.size() == 0) || rdy});
        check("out_valid", {71'd0, out_valid}, {71'd0, q.size() != 0});
        if (!seen_valid && out_valid === 1'b1) begin
            seen_valid  = 1'b1;
            valid_after = acc_cnt;
        end
        if (q.size() != 0) begin
            check("out_window", out_window, q[0].win);
            check("out_last", {71'd0, out_last}, {71'd0, q[0].last});
        end
        acc = v && ((q.size() == 0) || rdy);
        if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (acc) model_accept(px);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_frame(input int kind, input int vpct, input int rpct,
                              input int stall, input int stop_at);
        int         idx = 0;
        int         guard = 0;
        int         st = stall;
        bit         acc, v, rdy;
        logic [7:0] px;
        while (idx < stop_at) begin
            case (kind)
                0:       px = 8'(idx);
                1:       px = 8'(idx + 50);
                2:       px = 8'($urandom);
                default: px = ($urandom_range(1) == 1) ? 8'h80 : 8'h7f;
            endcase
            v = ($urandom_range(99) < vpct);
            if (st > 0 && q.size() != 0) begin
                rdy = 1'b0;
                st--;
            end else begin
                rdy = ($urandom_range(99) < rpct);
            end
            tick(v, px, rdy, acc);
            if (acc) begin
                if (kind == 0 && idx == 12) begin
                    check("ramp_first_valid", {71'd0, out_valid}, 72'd1);
                    check("ramp_first_win", out_window, ramp_first);
                end
                if (kind == 0 && idx == 24) begin
                    check("ramp_last_flag", {71'd0, out_last}, 72'd1);
                    check("ramp_last_win", out_window, ramp_last);
                end
                idx++;
            end
            guard++;
            if (guard > 2000) begin
                check("feed_timeout", 72'(guard), 72'd2000);
                break;
            end
        end
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            tick(1'b0, 8'd0, 1'b1, acc);
            guard++;
        end
        check("drain_timeout", 72'(q.size()), 72'd0);
        tick(1'b0, 8'd0, 1'b1, acc);
    endtask

    initial begin
        int first_list [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int last_list  [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        int pop0;
        bit acc;
        for (int k = 0; k < 9; k++) begin
            ramp_first[k*8 +: 8] = 8'(first_list[k]);
            ramp_last[k*8 +: 8]  = 8'(last_list[k]);
        end

        reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", {71'd0, in_ready}, 72'd1);
        check("rst_out_valid", {71'd0, out_valid}, 72'd0);
        check("rst_out_last", {71'd0, out_last}, 72'd0);
        check("rst_out_window", out_window, 72'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        pop0 = n_pop;
        feed_frame(0, 100, 100, 0, 25);
        drain();
        check("ramp_count", 72'(n_pop - pop0), 72'd9);

        pop0 = n_pop;
        feed_frame(0, 100, 100, 4, 25);
        drain();
        check("stall_count", 72'(n_pop - pop0), 72'd9);

        pop0 = n_pop;
        feed_frame(2, 60, 100, 0, 25);
        feed_frame(0, 40, 70, 0, 25);
        drain();
        check("bubble_count", 72'(n_pop - pop0), 72'd18);

        pop0 = n_pop;
        feed_frame(0, 100, 100, 0, 25);
        feed_frame(1, 100, 100, 0, 25);
        feed_frame(3, 80, 60, 2, 25);
        drain();
        check("b2b_count", 72'(n_pop - pop0), 72'd27);

        feed_frame(2, 100, 100, 0, 18);
        tick(1'b0, 8'd0, 1'b0, acc);
        check("stalled_valid", {71'd0, out_valid}, 72'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", {71'd0, out_valid}, 72'd0);
        check("midrst_in_ready", {71'd0, in_ready}, 72'd1);
        check("midrst_out_window", out_window, 72'd0);
        q.delete();
        mr = 0; mc = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        acc_cnt = 0; seen_valid = 1'b0; valid_after = -1;
        pop0 = n_pop;
        feed_frame(2, 100, 100, 0, 25);
        drain();
        check("post_reset_first_at", 72'(valid_after), 72'd13);
        check("post_reset_count", 72'(n_pop - pop0), 72'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that sits directly upstream of the convolution MAC. It accepts signed pixels in raster order with a valid/ready handshake. Two internal line buffers rebuild each KERNEL_SIZE x KERNEL_SIZE neighbourhood (valid convolution, no padding). It presents the window as one flat bus that the MAC slices into its `data` operand.

## Interface
- `WIDTH`, 8: pixel width, signed two's complement.
- `KERNEL_SIZE`, 3: window edge; only 3 is supported.
- `IMG_WIDTH`, 32: pixels per row, ≥ 3.
- `IMG_HEIGHT`, 32: rows per frame, ≥ 3.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_pixel` in WIDTH: incoming pixel, raster order.
- `in_valid` in 1: `in_pixel` is valid.
- `in_ready` out 1: block can accept a pixel.
- `out_window` out KERNEL_SIZE*KERNEL_SIZE*WIDTH: element k occupies bits [k*WIDTH +: WIDTH]. k = r*3+c, with r=0 as the oldest row and c=0 as the leftmost column. k=8 is the newest pixel.
- `out_valid` out 1: `out_window` is valid.
- `out_ready` in 1: downstream accepts the window.
- `out_last` out 1: qualifies the final window of a frame; meaningful only while `out_valid` is high.

## Operation
- **Accept rule.** A pixel is accepted on a rising edge where `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`, combinational.
  - Nothing else stalls input.
- **Counters.** `col` runs 0..IMG_WIDTH-1. `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on accept.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0, so the next accepted pixel starts a new frame with no gap required.
- **Line buffers.** `lb0` holds the previous row and `lb1` holds the row before that; each has depth IMG_WIDTH.
  - On accept at `col`, read `lb1[col]` and `lb0[col]`.
  - Then write `lb1[col] <= lb0[col]` and `lb0[col] <= in_pixel`, read-before-write.
- **Window register.** On accept, all three columns shift left by one.
  - The new right column is {`lb1[col]`, `lb0[col]`, `in_pixel`}, filling k=2, 5, 8 respectively.
  - The register does not change when no pixel is accepted.
- **Output.** On an accept with `row ≥ 2 && col ≥ 2`, set `out_valid`. Set `out_last` if the pixel is the frame's final pixel.
  - An accept that produces no window while `out_ready` is high clears `out_valid`.
  - With no accept, `out_ready` clears `out_valid`.
  - Otherwise `out_valid` holds.
- **Window count.** Each frame produces exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
- **Arithmetic.** No arithmetic on pixel values: bits pass through unchanged and the sign is preserved.
- **Stale data.** Line-buffer contents are not reset. Stale data is never emitted because of the `row ≥ 2`, `col ≥ 2` gate.

## Timing
- **Reset values:** `out_valid` 0, `out_last` 0, `out_window` all 0, `row`/`col` 0.
  - `in_ready` reads 1 during and after reset.
- **Latency:** 1 cycle. `out_valid` rises on the edge that accepts the completing pixel.
- **Throughput:** 1 pixel/cycle when `out_ready` is held high. No bubbles are inserted.
- **Stall:** while `out_valid && !out_ready`:
  - `out_window` and `out_last` are stable;
  - `in_ready` is 0;
  - counters and line buffers are frozen.
- **Simultaneous accept and drain:** a window accepted at the same edge a new one is produced is replaced with no gap.
- **Reset mid-frame:** counters return to 0 and pending output is dropped. The next pixel is treated as (0,0).
- **Row edges:** windows at col 0 and 1 of any row are suppressed even though the window register holds mixed-row data.

## Structure
- **Shared package `cnn_pkg`:**
  - `WIDTH`, `KERNEL_SIZE`, `ACCM_WIDTH` defaults;
  - `WIN_ELEMS = KERNEL_SIZE*KERNEL_SIZE`;
  - a pixel typedef `pixel_t` (signed [WIDTH-1:0]);
  - a helper for computing window element bit offsets.
- **Sub-module `line_buffer_ram`:** parameterised depth/width, one read and one write address per cycle, read-before-write, no reset on contents. It is instantiated twice.
- **Top-level logic:** counters, window shift register and the output handshake.

## Test plan
- **5x5 ramp, pixel = r*5+c, out_ready=1.**
  - First `out_valid` follows the accept of pixel 12, window = 0,1,2,5,6,7,10,11,12.
  - 9 windows total.
  - `out_last` only on the window completed by pixel 24 (12..14,17..19,22..24).
- **Backpressure.** Same image with `out_ready` low for 4 cycles after the first window.
  - Window is held bit-stable and `in_ready` is 0.
  - After release, all 9 windows match the golden model with no loss or duplication.
- **Input bubbles.** Random `in_valid` gaps: window sequence identical to the gap-free run.
- **Back-to-back frames.** Two frames with no idle cycle: the second frame's first window is 0,1,2,5,6,7,10,11,12 of frame 2, with no data from frame 1.
- **Extremes.** Pixels alternating -128/127: emitted bits are identical, sign intact.
- **Reset mid-frame.** Assert `reset` after pixel 17 while a window is stalled.
  - `out_valid` drops immediately (async).
  - Next frame's first window appears after its 13th pixel.
